// File: rtl/async_sync_chain.sv
`timescale 1ns/1ps
// async_sync_chain
// Simulation model of a multi-stage synchroniser that checks setup/hold
// timing on an asynchronous data input at every clock rise and resolves
// violating bits in a configurable way.
//
// Ports:
//   CP       - clock; all state changes on its rising edge (or edge+RD)
//   CLR      - asynchronous active-low reset
//   D        - asynchronous data input, DW bits
//   CNT_CLR  - synchronous clear of VIOL_CNT and the message count
//   Q        - synchronised data (last stage)
//   META     - per-bit violation flags of the latest stage-1 sample
//   VIOL_CNT - saturating count of clock edges with any violating bit
//
// Simulation only: the timing windows are built from delay controls.
module async_sync_chain #(
    parameter int unsigned DW      = 1,
    parameter int unsigned STAGES  = 2,
    parameter real         TS      = 0.5,
    parameter real         TH      = 0.5,
    parameter real         RD      = 1.0,
    parameter int unsigned MODE    = 0,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MSG_MAX = 16
) (
    input  logic             CP,
    input  logic             CLR,
    input  logic [DW-1:0]    D,
    input  logic             CNT_CLR,
    output logic [DW-1:0]    Q,
    output logic [DW-1:0]    META,
    output logic [CNT_W-1:0] VIOL_CNT
);

    logic [DW-1:0]  r_stage [STAGES];
    logic [15:0]    r_lfsr;
    logic [DW-1:0]  r_d_setup;

    // Per-edge samples, handed from the sampling process to the state process.
    logic [DW-1:0]  r_smp_s;
    logic [DW-1:0]  r_smp_c;
    logic [DW-1:0]  r_smp_h;
    logic [15:0]    r_smp_lfsr;
    logic           r_smp_clr;
    int unsigned    r_smp_gen;

    // Reset generation: bumped on every reset so that a resolution sampled
    // before CLR assertion is recognised as stale and dropped.
    int unsigned    r_gen      = 0;
    logic           r_res_tick = 1'b0;
    logic           r_res_ack  = 1'b0;
    int unsigned    r_msg_cnt  = 0;

    logic [DW-1:0]  w_viol;
    logic [DW-1:0]  w_stage1_new;

    // Transport-delayed copy of D: its value at the edge is D at edge-TS.
    always @(D) r_d_setup <= #(TS) D;

    // Sample S and C at the edge, H at edge+TH, then signal resolution at edge+RD.
    always @(posedge CP) begin
        if (CLR) begin
            r_smp_s    <= r_d_setup;
            r_smp_c    <= D;
            r_smp_lfsr <= r_lfsr;
            r_smp_clr  <= CNT_CLR;
            r_smp_gen  <= r_gen;
            #(TH);
            r_smp_h    <= D;
            #(RD - TH);
            r_res_tick <= ~r_res_tick;
        end
    end

    always_comb begin
        w_viol       = '0;
        w_stage1_new = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            w_viol[i] = (r_smp_s[i] !== r_smp_c[i]) || (r_smp_c[i] !== r_smp_h[i]);
            if (!w_viol[i])
                w_stage1_new[i] = r_smp_c[i];
            else if (MODE == 1)
                w_stage1_new[i] = r_stage[0][i];
            else if (MODE == 2)
                w_stage1_new[i] = r_smp_lfsr[i % 16];
            else
                w_stage1_new[i] = 1'b0;
        end
    end

    // One process owns all state: reset, clock-edge shifting and the
    // edge+RD resolution (recognised by an unacknowledged tick toggle).
    always @(posedge CP or negedge CLR or r_res_tick) begin
        if (!CLR) begin
            for (int unsigned i = 0; i < STAGES; i++)
                r_stage[i] <= '0;
            META      <= '0;
            VIOL_CNT  <= '0;
            r_lfsr    <= SEED;
            r_gen     <= r_gen + 1;
            r_res_ack <= r_res_tick;
        end else if (r_res_tick != r_res_ack) begin
            r_res_ack <= r_res_tick;
            if (r_smp_gen == r_gen) begin
                r_stage[0] <= w_stage1_new;
                META       <= w_viol;
                if (|w_viol) begin
                    if (!r_smp_clr && (VIOL_CNT != '1))
                        VIOL_CNT <= VIOL_CNT + 1'b1;
                    if (r_msg_cnt < MSG_MAX) begin
                        $display("async_sync_chain timing violation: %m t=%0t META=%b",
                                 $time, w_viol);
                        r_msg_cnt <= r_msg_cnt + 1;
                    end
                end
            end
        end else begin
            for (int unsigned i = 1; i < STAGES; i++)
                r_stage[i] <= r_stage[i-1];
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
            if (CNT_CLR) begin
                VIOL_CNT  <= '0;
                r_msg_cnt <= 0;
            end
        end
    end

    assign Q = r_stage[STAGES-1];

endmodule
